// File: rtl/rx_phase_align_pkg.sv
// Shared definitions for the receive phase aligner: state encoding and width helpers.
package rx_phase_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_SELECT = 2'd2,
        ST_LOCKED = 2'd3
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // |x| of an nb-bit two's complement sample fits nb-1 bits once -2^(nb-1) saturates
    function automatic int abs_width(input int nb);
        return nb - 1;
    endfunction

    function automatic int acc_width(input int nb, input int window);
        return abs_width(nb) + clog2(window);
    endfunction

endpackage

// File: rtl/rx_phase_align_metric_acc.sv
// One per-phase energy accumulator: adds the saturated magnitude of its tap on add_en.
module phase_metric_acc
    import rx_phase_pkg::*;
#(
    parameter int NB = 8,
    parameter int AW = acc_width(8, 64)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          add_en,
    input  logic [NB-1:0] sample,
    output logic [AW-1:0] acc
);

    localparam int MW = abs_width(NB);

    logic [NB-1:0] neg_next;
    logic [MW-1:0] mag_next;
    logic [AW-1:0] acc_reg;

    assign neg_next = (~sample) + NB'(1);

    always_comb begin
        mag_next = '0;
        if (sample == {1'b1, {(NB-1){1'b0}}}) begin
            mag_next = {MW{1'b1}};
        end else if (sample[NB-1]) begin
            mag_next = neg_next[MW-1:0];
        end else begin
            mag_next = sample[MW-1:0];
        end
    end

    // clear wins over add so a strobe coinciding with a restart is discarded
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
        end else if (add_en) begin
            acc_reg <= acc_reg + AW'(mag_next);
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/rx_phase_align.sv
// Picks the oversampling phase with the largest magnitude energy over a symbol window.
// Build option RX_PHASE_TRACK_EN keeps re-selecting the phase every window while locked.
module rx_phase_align
    import rx_phase_pkg::*;
#(
    parameter int NB     = 8,
    parameter int OS     = 4,
    parameter int WINDOW = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_enable,
    input  logic [NB-1:0]       i_sample,
    input  logic                i_valid,
    input  logic                i_restart,
    output logic [clog2(OS)-1:0] o_offset,
    output logic                o_bit,
    output logic                o_bit_valid,
    output logic                o_locked
);

    localparam int OW = clog2(OS);
    localparam int CW = clog2(WINDOW);
    localparam int AW = acc_width(NB, WINDOW);
`ifdef RX_PHASE_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    state_e                 state_reg;
    state_e                 state_next;
    logic [OS-1:0][NB-1:0]  buf_reg;
    logic [AW-1:0]          acc_val [OS];
    logic [AW-1:0]          best_val;
    logic [OW-1:0]          best_idx;
    logic [CW-1:0]          cnt_reg;
    logic [OW-1:0]          offset_reg;
    logic                   bit_reg;
    logic                   bit_valid_reg;
    logic                   track_sel_reg;
    logic                   restart_req;
    logic                   acc_en;
    logic                   acc_clear;
    logic                   window_done;
    logic                   select_now;
    logic                   load_offset;

    assign restart_req = i_enable && i_restart && (state_reg != ST_IDLE);
    assign acc_en      = i_enable && !restart_req && i_valid &&
                         ((state_reg == ST_ACQ) || (TRACK && (state_reg == ST_LOCKED)));
    assign window_done = acc_en && (cnt_reg == CW'(WINDOW - 1));
    assign select_now  = (state_reg == ST_SELECT) || track_sel_reg;
    assign load_offset = select_now && i_enable && !restart_req;
    assign acc_clear   = !i_enable || restart_req || select_now;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_reg <= '0;
        end else if (!i_enable) begin
            buf_reg <= '0;
        end else begin
            buf_reg <= {buf_reg[OS-2:0], i_sample};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < OS; gi++) begin : g_metric
            phase_metric_acc #(
                .NB (NB),
                .AW (AW)
            ) u_acc (
                .clock  (clock),
                .reset  (reset),
                .clear  (acc_clear),
                .add_en (acc_en),
                .sample (buf_reg[gi]),
                .acc    (acc_val[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (acc_clear) begin
            cnt_reg <= '0;
        end else if (acc_en) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    // strict greater-than keeps the lowest index on ties
    always_comb begin
        best_idx = '0;
        best_val = acc_val[0];
        for (int k = 1; k < OS; k++) begin
            if (acc_val[k] > best_val) begin
                best_val = acc_val[k];
                best_idx = OW'(k);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (i_enable) state_next = ST_ACQ;
            ST_ACQ:    if (window_done) state_next = ST_SELECT;
            ST_SELECT: state_next = ST_LOCKED;
            ST_LOCKED: state_next = ST_LOCKED;
            default:   state_next = ST_IDLE;
        endcase
        if (restart_req) state_next = ST_ACQ;
        if (!i_enable)   state_next = ST_IDLE;
    end

    always_comb begin
        o_locked = (state_reg == ST_LOCKED);
    end

    // tracking re-selects in the cycle after a window ends without leaving LOCKED
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            offset_reg    <= '0;
            bit_reg       <= 1'b0;
            bit_valid_reg <= 1'b0;
            track_sel_reg <= 1'b0;
        end else begin
            if (load_offset) offset_reg <= best_idx;
            track_sel_reg <= (state_reg == ST_LOCKED) && window_done;
            bit_valid_reg <= 1'b0;
            if ((state_reg == ST_LOCKED) && i_valid && i_enable && !restart_req) begin
                bit_reg       <= buf_reg[offset_reg][NB-1];
                bit_valid_reg <= 1'b1;
            end
        end
    end

    assign o_offset    = offset_reg;
    assign o_bit       = bit_reg;
    assign o_bit_valid = bit_valid_reg;

endmodule
